// File: rtl/hazard_pkg.sv
// Shared types for the RV32I hazard controller: forwarding selects, memory-wait states, result-select codes.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FAULT = 2'd2
  } mem_state_t;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'd1;

endpackage

// File: rtl/hazard_controller_forward_sel.sv
// One EX operand's forwarding select; the Memory stage wins over Writeback when both match.
module forward_sel
  import hazard_pkg::*;
(
  input  logic       reg_write_m,
  input  logic [4:0] rd_m,
  input  logic       reg_write_w,
  input  logic [4:0] rd_w,
  input  logic [4:0] rs_e,
  input  logic       rs_signal_e,
  output fwd_sel_t   fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs_e) && rs_signal_e) fwd = FWD_W;
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs_e) && rs_signal_e) fwd = FWD_M;
  end

endmodule

// File: rtl/hazard_controller.sv
// 5-stage RV32I hazard controller: forwarding, load-use stall, redirect flush, memory-wait FSM with watchdog.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  input  logic        rs1_signal_d,
  input  logic        rs2_signal_d,
  input  logic [4:0]  rs1_e,
  input  logic [4:0]  rs2_e,
  input  logic        rs1_signal_e,
  input  logic        rs2_signal_e,
  input  logic [4:0]  rd_e,
  input  logic [1:0]  result_src_e,
  input  logic        pc_src_e,
  input  logic        reg_write_m,
  input  logic [4:0]  rd_m,
  input  logic        reg_write_w,
  input  logic [4:0]  rd_w,
  input  logic        mem_req_m,
  input  logic        mem_ready,
  output logic [1:0]  forward_a_e,
  output logic [1:0]  forward_b_e,
  output logic        stall_f,
  output logic        stall_d,
  output logic        stall_e,
  output logic        stall_m,
  output logic        flush_d,
  output logic        flush_e,
  output logic        flush_w,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] redirect_count
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  fwd_sel_t fwd_a;
  fwd_sel_t fwd_b;

  forward_sel u_fwd_a (
    .reg_write_m (reg_write_m),
    .rd_m        (rd_m),
    .reg_write_w (reg_write_w),
    .rd_w        (rd_w),
    .rs_e        (rs1_e),
    .rs_signal_e (rs1_signal_e),
    .fwd         (fwd_a)
  );

  forward_sel u_fwd_b (
    .reg_write_m (reg_write_m),
    .rd_m        (rd_m),
    .reg_write_w (reg_write_w),
    .rd_w        (rd_w),
    .rs_e        (rs2_e),
    .rs_signal_e (rs2_signal_e),
    .fwd         (fwd_b)
  );

  assign forward_a_e = rst_n ? fwd_a : FWD_RF;
  assign forward_b_e = rst_n ? fwd_b : FWD_RF;

  logic lu;
  logic ms;

  always_comb begin
    lu = (result_src_e == RESULT_SRC_LOAD) && (rd_e != 5'd0) &&
         (((rs1_d == rd_e) && rs1_signal_d) || ((rs2_d == rd_e) && rs2_signal_d));
  end

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // ms drops in the same cycle mem_ready arrives, so a hit never costs a stall cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ms      = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_req_m && !mem_ready) begin
          ms      = 1'b1;
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (mem_ready) begin
          state_d = IDLE;
        end else begin
          ms = 1'b1;
          if (cnt_q == CNT_LAST) state_d = FAULT;
          else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FAULT:   ms = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (rst_n) begin
      if (ms) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (pc_src_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (lu) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  assign mem_timeout = rst_n && (state_q == FAULT);

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] redirect_count_q, redirect_count_d;
  logic        any_stall;

  always_comb begin
    any_stall        = stall_f | stall_d | stall_e | stall_m;
    stall_cycles_d   = stall_cycles_q + 32'(any_stall);
    redirect_count_d = redirect_count_q + 32'(flush_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles_q   <= '0;
      redirect_count_q <= '0;
    end else begin
      stall_cycles_q   <= stall_cycles_d;
      redirect_count_q <= redirect_count_d;
    end
  end

  assign stall_cycles   = rst_n ? stall_cycles_q : 32'd0;
  assign redirect_count = rst_n ? redirect_count_q : 32'd0;
`else
  assign stall_cycles   = 32'd0;
  assign redirect_count = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed and randomized bench for hazard_controller against a cycle-level behavioural model.
module tb_hazard_controller;

  localparam int MT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic        rs1_signal_d, rs2_signal_d, rs1_signal_e, rs2_signal_e;
  logic [1:0]  result_src_e;
  logic        pc_src_e, reg_write_m, reg_write_w, mem_req_m, mem_ready;
  logic [1:0]  forward_a_e, forward_b_e;
  logic        stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, mem_timeout;
  logic [31:0] stall_cycles, redirect_count;

  hazard_controller #(.MEM_TIMEOUT(MT), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_signal_d(rs1_signal_d), .rs2_signal_d(rs2_signal_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rs1_signal_e(rs1_signal_e), .rs2_signal_e(rs2_signal_e),
    .rd_e(rd_e), .result_src_e(result_src_e), .pc_src_e(pc_src_e),
    .reg_write_m(reg_write_m), .rd_m(rd_m), .reg_write_w(reg_write_w), .rd_w(rd_w),
    .mem_req_m(mem_req_m), .mem_ready(mem_ready),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .redirect_count(redirect_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state: how many cycles the current miss has lasted, sticky fault, perf totals.
  int          miss_age  = 0;
  bit          faulted   = 1'b0;
  logic [31:0] stall_cnt = 32'd0;
  logic [31:0] redir_cnt = 32'd0;

  logic [1:0]  e_fa, e_fb;
  logic        e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw, e_to;
  logic [31:0] e_sc, e_rc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd_of(input logic [4:0] rs, input logic sig);
    if (reg_write_m && rd_m != 0 && rd_m == rs && sig) return 2'b10;
    if (reg_write_w && rd_w != 0 && rd_w == rs && sig) return 2'b01;
    return 2'b00;
  endfunction

  task automatic compute();
    bit lu, ms;
    lu = (result_src_e == 2'd1) && (rd_e != 0) &&
         ((rs1_d == rd_e && rs1_signal_d) || (rs2_d == rd_e && rs2_signal_d));
    if (faulted)       ms = 1'b1;
    else if (miss_age > 0) ms = !mem_ready;
    else               ms = mem_req_m && !mem_ready;
    e_fa = fwd_of(rs1_e, rs1_signal_e);
    e_fb = fwd_of(rs2_e, rs2_signal_e);
    e_sf = ms || (!pc_src_e && lu);
    e_sd = e_sf;
    e_se = ms;
    e_sm = ms;
    e_fd = !ms && pc_src_e;
    e_fe = !ms && (pc_src_e || lu);
    e_fw = ms;
    e_to = faulted;
`ifdef HAZARD_PERF_EN
    e_sc = stall_cnt;
    e_rc = redir_cnt;
`else
    e_sc = 32'd0;
    e_rc = 32'd0;
`endif
    if (!rst_n) begin
      {e_fa, e_fb} = '0;
      {e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw, e_to} = '0;
      e_sc = 32'd0;
      e_rc = 32'd0;
    end
  endtask

  task automatic update_model();
    if (!rst_n) begin
      miss_age  = 0;
      faulted   = 1'b0;
      stall_cnt = 32'd0;
      redir_cnt = 32'd0;
    end else begin
      if (e_sf || e_sd || e_se || e_sm) stall_cnt = stall_cnt + 32'd1;
      if (e_fd) redir_cnt = redir_cnt + 32'd1;
      if (!faulted) begin
        if (miss_age == 0) begin
          if (mem_req_m && !mem_ready) miss_age = 1;
        end else if (mem_ready) begin
          miss_age = 0;
        end else if (miss_age == MT) begin
          faulted  = 1'b1;
          miss_age = 0;
        end else begin
          miss_age++;
        end
      end
    end
  endtask

  // Check all outputs mid-cycle, then advance one clock and the model with it.
  task automatic cycle();
    #2;
    compute();
    chk("forward_a_e", 32'(forward_a_e), 32'(e_fa));
    chk("forward_b_e", 32'(forward_b_e), 32'(e_fb));
    chk("stall_f", 32'(stall_f), 32'(e_sf));
    chk("stall_d", 32'(stall_d), 32'(e_sd));
    chk("stall_e", 32'(stall_e), 32'(e_se));
    chk("stall_m", 32'(stall_m), 32'(e_sm));
    chk("flush_d", 32'(flush_d), 32'(e_fd));
    chk("flush_e", 32'(flush_e), 32'(e_fe));
    chk("flush_w", 32'(flush_w), 32'(e_fw));
    chk("mem_timeout", 32'(mem_timeout), 32'(e_to));
    chk("stall_cycles", stall_cycles, e_sc);
    chk("redirect_count", redirect_count, e_rc);
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic clear_inputs();
    rst_n = 1'b1;
    {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
    {rs1_signal_d, rs2_signal_d, rs1_signal_e, rs2_signal_e} = '0;
    result_src_e = 2'd0;
    {pc_src_e, reg_write_m, reg_write_w, mem_req_m, mem_ready} = '0;
  endtask

  initial begin
    int ms_seen;
    clear_inputs();

    // Reset with busy inputs: everything must read zero.
    rst_n = 1'b0; mem_req_m = 1'b1; pc_src_e = 1'b1;
    reg_write_m = 1'b1; rd_m = 5'd3; rs1_e = 5'd3; rs1_signal_e = 1'b1;
    #2;
    chk("rst_fwd_a", 32'(forward_a_e), 32'd0);
    chk("rst_flush_d", 32'(flush_d), 32'd0);
    cycle();
    cycle();

    // M has priority over W; rd_m = 0 falls back to W.
    clear_inputs();
    reg_write_m = 1'b1; rd_m = 5'd5; reg_write_w = 1'b1; rd_w = 5'd5;
    rs1_e = 5'd5; rs1_signal_e = 1'b1;
    #2; chk("fwd_a_m", 32'(forward_a_e), 32'd2);
    cycle();
    rd_m = 5'd0;
    #2; chk("fwd_a_w", 32'(forward_a_e), 32'd1);
    cycle();

    // Load-use on rs2, then the same with rs2 not read.
    clear_inputs();
    result_src_e = 2'd1; rd_e = 5'd7; rs2_d = 5'd7; rs2_signal_d = 1'b1;
    #2; chk("lu_stall_f", 32'(stall_f), 32'd1); chk("lu_flush_e", 32'(flush_e), 32'd1);
    cycle();
    rs2_signal_d = 1'b0;
    #2; chk("lu_nosig", 32'(stall_f), 32'd0);
    cycle();

    // Redirect overrides load-use.
    rs2_signal_d = 1'b1; pc_src_e = 1'b1;
    #2; chk("redir_flush_d", 32'(flush_d), 32'd1); chk("redir_stall_f", 32'(stall_f), 32'd0);
    cycle();

    // Three-cycle memory wait.
    clear_inputs();
    mem_req_m = 1'b1;
    ms_seen = 0;
    for (int i = 0; i < 3; i++) begin
      #2; if (stall_m) ms_seen++;
      cycle();
    end
    mem_ready = 1'b1;
    #2; if (stall_m) ms_seen++;
    cycle();
    chk("ms_len", 32'(ms_seen), 32'd3);
    mem_req_m = 1'b0; mem_ready = 1'b0;
    cycle();

    // Watchdog: FAULT after the fifth miss cycle, then reset clears it.
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    mem_req_m = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #2; chk("pre_fault", 32'(mem_timeout), 32'd0);
      cycle();
    end
    #2; chk("fault", 32'(mem_timeout), 32'd1); chk("fault_stall", 32'(stall_f), 32'd1);
    cycle();
    mem_ready = 1'b1; mem_req_m = 1'b0;
    #2; chk("fault_hold", 32'(stall_m), 32'd1);
    cycle();
    rst_n = 1'b0;
    #2; chk("fault_rst", 32'(stall_m), 32'd0); chk("fault_rst_to", 32'(mem_timeout), 32'd0);
    cycle();
    rst_n = 1'b1; mem_ready = 1'b0;
    #2; chk("post_rst_idle", 32'(stall_m), 32'd0);
    cycle();

    // Randomized traffic with a narrow register range to provoke matches.
    for (int n = 0; n < 2000; n++) begin
      rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
      rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
      rd_e  = 5'($urandom_range(0, 3)); rd_m  = 5'($urandom_range(0, 3));
      rd_w  = 5'($urandom_range(0, 3));
      rs1_signal_d = 1'($urandom_range(0, 1)); rs2_signal_d = 1'($urandom_range(0, 1));
      rs1_signal_e = 1'($urandom_range(0, 1)); rs2_signal_e = 1'($urandom_range(0, 1));
      result_src_e = 2'($urandom_range(0, 3));
      reg_write_m  = 1'($urandom_range(0, 1)); reg_write_w = 1'($urandom_range(0, 1));
      pc_src_e  = ($urandom_range(0, 3) == 0);
      mem_req_m = ($urandom_range(0, 2) == 0);
      mem_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 7) == 0) mem_ready = 1'b0;
      rst_n = !(($urandom_range(0, 199) == 0) || (faulted && $urandom_range(0, 2) == 0));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline scheduler for the 5-stage RV32I core: EX-stage forwarding selects, load-use stall, control-redirect flush, data-memory wait sequencing.
- Consumes per-stage register indices and the decoder's rs1_signal/rs2_signal, result_src, reg_write qualifiers.
- Drives stall/flush enables of the F/D, D/E, E/M, M/W pipeline registers.
- Contains a memory-wait FSM with a timeout watchdog.

Parameters:
- MEM_TIMEOUT, 64, wait cycles in WAIT before declaring a memory fault (legal range 2..65535).
- CNT_W, 16, width of the wait counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous reset, active-low
- rs1_d, rs2_d  in  5 each  source registers in Decode
- rs1_signal_d, rs2_signal_d  in  1 each  source actually read in Decode
- rs1_e, rs2_e  in  5 each  source registers in Execute
- rs1_signal_e, rs2_signal_e  in  1 each  source actually read in Execute
- rd_e  in  5  destination in Execute
- result_src_e  in  2  result select in Execute; 2'd1 = load
- pc_src_e  in  1  taken branch/jump/jalr resolved in Execute
- reg_write_m, rd_m  in  1, 5  Memory-stage writeback qualifier and destination
- reg_write_w, rd_w  in  1, 5  Writeback-stage writeback qualifier and destination
- mem_req_m  in  1  load/store active in Memory
- mem_ready  in  1  data memory completes the access this cycle
- forward_a_e, forward_b_e  out  2 each  00 = register file, 01 = W result, 10 = M ALU result
- stall_f, stall_d, stall_e, stall_m  out  1 each  hold stage register
- flush_d, flush_e, flush_w  out  1 each  insert bubble into stage register
- mem_timeout  out  1  sticky memory fault
- stall_cycles, redirect_count  out  32 each  performance counters (see Optional Feature)

Behaviour:
- Reset: clk and rst_n only; synchronous, active-low.
  - While rst_n = 0: all outputs read 0, FSM goes to IDLE, wait counter 0, mem_timeout 0.
  - Reset taking effect mid-WAIT returns to IDLE on that clock edge.
- Forwarding (combinational, zero latency). For operand A:
  - 10 if reg_write_m, rd_m != 0, rd_m == rs1_e and rs1_signal_e;
  - else 01 if the same conditions hold for W (reg_write_w, rd_w);
  - else 00.
  - M has priority over W. Operand B is identical using rs2_e / rs2_signal_e.
- Load-use (lu): result_src_e == 1, rd_e != 0, and (rs1_d == rd_e with rs1_signal_d, or rs2_d == rd_e with rs2_signal_d).
- Memory stall (ms): asserted when state == WAIT, or when state == IDLE with mem_req_m = 1 and mem_ready = 0. Asserted whenever state == FAULT.
- Output priority:
  1. ms: stall_f = stall_d = stall_e = stall_m = 1, flush_w = 1, flush_d = flush_e = 0. Pending redirect/lu are re-evaluated once ms drops.
  2. pc_src_e: flush_d = flush_e = 1, stall_f = stall_d = 0. Redirect overrides lu.
  3. lu: stall_f = stall_d = 1, flush_e = 1.
  4. Otherwise all stall/flush outputs = 0.
- FSM states: IDLE, WAIT, FAULT.
  - IDLE -> WAIT on mem_req_m & !mem_ready; wait counter cleared to 0.
  - WAIT, mem_ready = 1: -> IDLE; ms is deasserted in that same cycle.
  - WAIT, mem_ready = 0: counter increments. When counter == MEM_TIMEOUT-1 and mem_ready is still 0 -> FAULT.
  - FAULT: mem_timeout = 1, all stalls held; exit only via reset.
  - mem_ready = 1 in IDLE with mem_req_m: no stall; single-cycle access.
- rd == 0 never forwards or triggers lu.
- Counter width: CNT_W must hold MEM_TIMEOUT-1; the counter saturates and never wraps.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - stall_cycles increments on each cycle with any stall_* asserted.
  - redirect_count increments on each cycle where pc_src_e is honoured (flush_d asserted).
  - Both 32-bit, wrap modulo 2^32, cleared by reset.
- Undefined: both ports tied to 0 and no counter flops are built.

Decomposition:
- Package hazard_pkg holds:
  - fwd_sel_t enum: FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10;
  - mem_state_t enum: IDLE, WAIT, FAULT;
  - constant RESULT_SRC_LOAD = 2'd1.
- Sub-module forward_sel: one operand's forwarding compare, instantiated twice (A and B).

Test Plan:
- add x5 (M, reg_write_m = 1, rd_m = 5) with rs1_e = 5, rs1_signal_e = 1 and rd_w = 5 also writing -> forward_a_e = 10. With rd_m = 0 -> forward_a_e = 01.
- lw x7 in E (result_src_e = 1, rd_e = 7), rs2_d = 7, rs2_signal_d = 1 -> stall_f = stall_d = flush_e = 1 for one cycle. Same with rs2_signal_d = 0 (lui-style) -> no stall.
- pc_src_e = 1 together with lu condition -> flush_d = flush_e = 1, stall_f = 0.
- mem_req_m = 1, mem_ready low for 3 cycles then high -> ms high for exactly 3 cycles, flush_w high for 3 cycles, FSM returns to IDLE. With HAZARD_PERF_EN, stall_cycles = 3.
- MEM_TIMEOUT = 4, mem_ready held low -> FAULT entered after cycle 5 of the request, mem_timeout = 1 and stalls held. Drive rst_n = 0 for one edge -> all outputs 0, state IDLE.
